// File: rtl/lieat_ifu_bpu_sched_pkg.sv
// Shared types for the IFU branch-predictor update scheduler.
package lieat_ifu_bpu_sched_pkg;

  localparam int BPU_IDX_W      = 4;
  localparam int BPU_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [BPU_IDX_W-1:0] index;
    logic                 taken;
  } upd_entry_t;

endpackage

// File: rtl/lieat_bpu_upd_fifo.sv
// Update-outcome buffer: synchronous FIFO with registered storage and a live count.
module lieat_bpu_upd_fifo
  import lieat_ifu_bpu_sched_pkg::*;
#(
  parameter  int DEPTH = BPU_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  upd_entry_t       i_push_data,
  input  logic             i_pop,
  output upd_entry_t       o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  upd_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which slots are valid.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/lieat_ifu_bpu_sched.sv
// Branch-predictor update scheduler: round-robin intake, FIFO-buffered updates, table-clear sweep.
module lieat_ifu_bpu_sched
  import lieat_ifu_bpu_sched_pkg::*;
#(
  parameter int IDX_W      = BPU_IDX_W,
  parameter int INDEX_NUM  = 1 << IDX_W,
  parameter int FIFO_DEPTH = BPU_FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDX_W-1:0] req0_index,
  input  logic             req0_taken,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDX_W-1:0] req1_index,
  input  logic             req1_taken,
  input  logic             clear_req,
  input  logic             dbg_pop_hold,
  output logic             prdt_en,
  output logic [IDX_W-1:0] prdt_index,
  output logic             prdt_result,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_index,
  output logic             busy
);

  localparam int             CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INDEX_NUM - 1);

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [IDX_W-1:0] r_clr_cnt;
  logic             r_rr;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  upd_entry_t       w_push_data;
  upd_entry_t       w_pop_data;

  // r_rr names the requester that wins when both are valid.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == ST_RUN && !w_full) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = !r_rr;
        w_grant1 = r_rr;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign w_push      = w_grant0 || w_grant1;
  assign w_push_data = w_grant1 ? '{index: req1_index, taken: req1_taken}
                                : '{index: req0_index, taken: req0_taken};
  assign w_pop       = (r_state != ST_CLEAR) && !w_empty && !dbg_pop_hold;

  lieat_bpu_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // DRAIN exits once the last entry has been popped; its strobe occupies the final DRAIN cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:   if (clear_req)             w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_count == '0)         w_state_nxt = ST_CLEAR;
      default:                             w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_rr      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_push)              r_rr      <= w_grant0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prdt_en     <= 1'b0;
      prdt_index  <= '0;
      prdt_result <= 1'b0;
    end else begin
      prdt_en <= w_pop;
      if (w_pop) begin
        prdt_index  <= w_pop_data.index;
        prdt_result <= w_pop_data.taken;
      end
    end
  end

  assign clr_en    = (r_state == ST_CLEAR);
  assign clr_index = r_clr_cnt;
  assign busy      = (r_state != ST_RUN);

endmodule

// File: tb/tb_lieat_ifu_bpu_sched.sv
// Scoreboard bench for lieat_ifu_bpu_sched: clear sweep, arbitration, buffering, drain and reset.
module tb_lieat_ifu_bpu_sched;

  localparam int IDX_W = 4;
  localparam int N_IDX = 16;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             tk;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [IDX_W-1:0] req0_index = '0, req1_index = '0;
  logic             req0_taken = 1'b0, req1_taken = 1'b0;
  logic             clear_req = 1'b0, dbg_pop_hold = 1'b0;
  logic             prdt_en, prdt_result, clr_en, busy;
  logic [IDX_W-1:0] prdt_index, clr_index;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_rr    = 1'b0;

  lieat_ifu_bpu_sched #(.IDX_W(IDX_W), .INDEX_NUM(N_IDX), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_index(req0_index), .req0_taken(req0_taken),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_index(req1_index), .req1_taken(req1_taken),
    .clear_req(clear_req), .dbg_pop_hold(dbg_pop_hold),
    .prdt_en(prdt_en), .prdt_index(prdt_index), .prdt_result(prdt_result),
    .clr_en(clr_en), .clr_index(clr_index), .busy(busy)
  );

  always #5 clock = ~clock;

  // Output side of the scoreboard: every update strobe must match the oldest accepted outcome.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b0) begin
      n_tests++;
      if (prdt_en && clr_en) begin
        n_fail++;
        $display("FAIL strobe_overlap: prdt_en=%b clr_en=%b, expected never both high", prdt_en, clr_en);
      end
      if (prdt_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL prdt_unexpected: index=%0d result=%b, expected no update", prdt_index, prdt_result);
        end else begin
          e = exp_q.pop_front();
          if (prdt_index !== e.idx || prdt_result !== e.tk) begin
            n_fail++;
            $display("FAIL prdt_order: got index=%0d result=%b, expected index=%0d result=%b",
                     prdt_index, prdt_result, e.idx, e.tk);
          end
        end
      end
    end
  end

  task automatic set_req(input logic v0, input logic [IDX_W-1:0] i0, input logic t0,
                         input logic v1, input logic [IDX_W-1:0] i1, input logic t1);
    req0_valid = v0; req0_index = i0; req0_taken = t0;
    req1_valid = v1; req1_index = i1; req1_taken = t1;
    #1;
  endtask

  // Record the outcome the bench expects to be accepted at the coming edge.
  task automatic push_exp(input logic which);
    exp_t e;
    e.idx = which ? req1_index : req0_index;
    e.tk  = which ? req1_taken : req0_taken;
    exp_q.push_back(e);
    m_rr = ~which;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic sweep_check(input string name);
    logic [IDX_W-1:0] ci;
    for (int c = 0; c < N_IDX; c++) begin
      ci = IDX_W'(c);
      n_tests++;
      if (clr_en !== 1'b1 || clr_index !== ci || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
          busy !== 1'b1 || prdt_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_cycle%0d: clr_en=%b clr_index=%0d rdy=%b%b busy=%b prdt_en=%b, expected 1 %0d 00 1 0",
                 name, c, clr_en, clr_index, req0_ready, req1_ready, busy, prdt_en, ci);
      end
      @(negedge clock); #1;
    end
    n_tests++;
    if (clr_en !== 1'b0 || busy !== 1'b0 || req0_ready !== !m_rr || req1_ready !== m_rr) begin
      n_fail++;
      $display("FAIL %s_end: clr_en=%b busy=%b rdy=%b%b, expected 0 0 %b%b",
               name, clr_en, busy, req0_ready, req1_ready, !m_rr, m_rr);
    end
    push_exp(m_rr);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_req(1'b1, 4'd3, 1'b1, 1'b1, 4'd6, 1'b0);
    n_tests++;
    if (prdt_en !== 1'b0 || prdt_index !== '0 || prdt_result !== 1'b0 || clr_en !== 1'b1 ||
        clr_index !== '0 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: prdt=%b/%0d/%b clr=%b/%0d busy=%b rdy=%b%b, expected 0/0/0 1/0 1 00",
               prdt_en, prdt_index, prdt_result, clr_en, clr_index, busy, req0_ready, req1_ready);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    sweep_check("sweep");
    @(negedge clock); #1;
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(4);
  endtask

  task automatic test_single;
    set_req(1'b1, 4'd5, 1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: rdy=%b%b, expected 10", req0_ready, req1_ready);
    end
    push_exp(1'b0);
    @(negedge clock); #1;
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    n_tests++;
    if (prdt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: prdt_en=%b one edge after accept, expected 0", prdt_en);
    end
    @(negedge clock); #1;
    n_tests++;
    if (prdt_en !== 1'b1 || prdt_index !== 4'd5 || prdt_result !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: prdt=%b/%0d/%b, expected 1/5/1", prdt_en, prdt_index, prdt_result);
    end
    idle(3);
  endtask

  task automatic test_round_robin;
    logic prev_w;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 4'd1, 1'b0, 1'b1, 4'd2, 1'b1);
      n_tests++;
      if (req0_ready !== !m_rr || req1_ready !== m_rr || (i > 0 && m_rr === prev_w)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: rdy=%b%b, expected %b%b alternating", i, req0_ready, req1_ready, !m_rr, m_rr);
      end
      prev_w = m_rr;
      push_exp(m_rr);
      @(negedge clock); #1;
      n_tests++;
      if (prdt_en !== (i >= 1)) begin
        n_fail++;
        $display("FAIL rr_rate%0d: prdt_en=%b, expected %b", i, prdt_en, (i >= 1));
      end
    end
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock); #1;
    n_tests++;
    if (prdt_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_rate4: prdt_en=%b, expected 1", prdt_en);
    end
    @(negedge clock); #1;
    n_tests++;
    if (prdt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_rate5: prdt_en=%b, expected 0", prdt_en);
    end
    idle(2);
  endtask

  task automatic test_fill;
    dbg_pop_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, IDX_W'(4 + k), k[0], 1'b0, '0, 1'b0);
      n_tests++;
      if (req0_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_push%0d: req0_ready=%b, expected 1", k, req0_ready);
      end
      push_exp(1'b0);
      @(negedge clock); #1;
    end
    set_req(1'b1, 4'd8, 1'b1, 1'b1, 4'd9, 1'b0);
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: rdy=%b%b, expected 00", req0_ready, req1_ready);
    end
    @(negedge clock); #1;
    dbg_pop_hold = 1'b0;
    #1;
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full_pop: rdy=%b%b with a pop pending, expected 00", req0_ready, req1_ready);
    end
    @(negedge clock); #1;
    dbg_pop_hold = 1'b1;
    #1;
    n_tests++;
    if (req0_ready !== !m_rr || req1_ready !== m_rr) begin
      n_fail++;
      $display("FAIL fill_resume: rdy=%b%b, expected %b%b", req0_ready, req1_ready, !m_rr, m_rr);
    end
    push_exp(m_rr);
    @(negedge clock); #1;
    dbg_pop_hold = 1'b0;
    set_req(1'b1, 4'd8, 1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_refull: req0_ready=%b, expected 0", req0_ready);
    end
    @(negedge clock); #1;
    n_tests++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_wrap_push: req0_ready=%b, expected 1", req0_ready);
    end
    push_exp(1'b0);
    @(negedge clock); #1;
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(8);
  endtask

  task automatic test_drain;
    int clr_cnt = 0;
    dbg_pop_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b0, '0, 1'b0, 1'b1, IDX_W'(12 + k), ~k[0]);
      n_tests++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_push%0d: rdy=%b%b, expected 01", k, req0_ready, req1_ready);
      end
      push_exp(1'b1);
      @(negedge clock); #1;
    end
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    clear_req    = 1'b1;
    dbg_pop_hold = 1'b0;
    @(negedge clock);
    clear_req = 1'b0;
    set_req(1'b1, 4'd11, 1'b1, 1'b0, '0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      n_tests++;
      if (prdt_en !== (j < 4) || clr_en !== (j >= 4) || req0_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_cycle%0d: prdt_en=%b clr_en=%b req0_ready=%b busy=%b, expected %b %b 0 1",
                 j, prdt_en, clr_en, req0_ready, busy, (j < 4), (j >= 4));
      end
      if (clr_en) clr_cnt++;
      @(negedge clock); #1;
    end
    for (int k = 0; k < 40 && busy; k++) begin
      if (clr_en) clr_cnt++;
      @(negedge clock); #1;
    end
    n_tests++;
    if (busy !== 1'b0 || clr_cnt != N_IDX || req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_sweep: busy=%b clr_cycles=%0d req0_ready=%b, expected 0 %0d 1",
               busy, clr_cnt, req0_ready, N_IDX);
    end
    push_exp(1'b0);
    @(negedge clock); #1;
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(4);
  endtask

  task automatic test_reset_mid_clear;
    bit found = 1'b0;
    clear_req = 1'b1;
    @(negedge clock); #1;
    clear_req = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (clr_en === 1'b1 && clr_index === 4'd7) found = 1'b1;
      else begin @(negedge clock); #1; end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL midclr_reach: clr_index=%0d clr_en=%b, expected sweep to reach index 7", clr_index, clr_en);
    end
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    m_rr = 1'b0;
    n_tests++;
    if (clr_index !== '0 || clr_en !== 1'b1 || prdt_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midclr_reset: clr=%b/%0d prdt_en=%b busy=%b, expected 1/0 0 1",
               clr_en, clr_index, prdt_en, busy);
    end
    set_req(1'b1, 4'd1, 1'b1, 1'b1, 4'd2, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    sweep_check("resweep");
    @(negedge clock); #1;
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midclr_rr: rdy=%b%b, expected 01", req0_ready, req1_ready);
    end
    push_exp(1'b1);
    @(negedge clock); #1;
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fill();
    test_drain();
    test_reset_mid_clear();
    idle(4);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d outcomes never issued, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/lieat_ifu_bpu_sched.md
# lieat_ifu_bpu_sched

Update scheduler and table-clear sequencer for the IFU branch predictor. It accepts resolved-branch outcomes from two execution requesters and arbitrates between them round-robin. Outcomes are buffered in a 4-entry FIFO and issued to the predictor's single update port at no more than one per cycle. After reset, and on request, it walks every predictor index to re-initialise the tables, and stalls all requesters while it does so.

## Interface
- IDX_W, `BPU_IDX: predictor index width.
- INDEX_NUM, 1 << IDX_W: number of predictor entries swept by a clear.
- FIFO_DEPTH, 4: update buffer depth; must be a power of two, at least 2.
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  resolved-branch outcome valid; req0 is the ALU pipe, req1 the second pipe.
- req0_ready / req1_ready  out  1  outcome accepted this cycle when valid && ready.
- req0_index / req1_index  in  IDX_W  predictor index of the branch.
- req0_taken / req1_taken  in  1  actual branch outcome.
- clear_req  in  1  single-cycle pulse requesting a full table clear.
- prdt_en  out  1  update strobe to the predictor; the predictor always accepts.
- prdt_index  out  IDX_W  update index.
- prdt_result  out  1  update outcome.
- clr_en  out  1  clear strobe for one predictor entry.
- clr_index  out  IDX_W  entry being cleared.
- busy  out  1  high in CLEAR or DRAIN.

## Operation
- FSM states: CLEAR, RUN, DRAIN. Reset state is CLEAR with sweep counter 0.
- **CLEAR**
  - Each cycle: clr_en=1, clr_index=counter, counter+1.
  - After the cycle with counter=INDEX_NUM-1, go to RUN. Counter wraps to 0.
  - Both readys are 0. clear_req is ignored.
- **RUN**
  - A grant is possible when FIFO is not full. At most one enqueue per cycle.
  - Only one requester valid: it gets ready=1.
  - Both valid: the requester named by the rr pointer gets ready=1, and the other gets 0.
  - rr pointer flips only on a granted enqueue, so the winner becomes lower priority next time. Reset value: req0 has priority.
  - FIFO full: both readys are 0.
  - ready is combinational from valid, FIFO count and state. It does not depend on the grant of the same cycle's dequeue, so full blocks even if a dequeue occurs.
- **Dequeue**
  - In RUN or DRAIN with the FIFO non-empty, pop the head every cycle.
  - Register the popped entry into prdt_en=1, prdt_index, prdt_result. Otherwise prdt_en=0, and index/result hold their last value.
- **clear_req in RUN**
  - Go to DRAIN; readys drop to 0 from the next cycle. A same-cycle handshake still completes.
  - DRAIN leaves for CLEAR once the FIFO is empty and the last prdt_en has issued.
  - clr_en and prdt_en are never high in the same cycle.
- Simultaneous enqueue and dequeue keep the count unchanged. Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Buffered outcomes are never dropped except by reset.

## Timing
- Reset values:
  - prdt_en=0, prdt_index=0, prdt_result=0.
  - clr_en=1, clr_index=0.
  - busy=1.
  - readys=0.
  - FIFO empty, rr pointer=0.
- clr_en and clr_index are decoded from state/counter (combinational).
- Clear sweep lasts exactly INDEX_NUM cycles after reset deassertion. req readys first rise in cycle INDEX_NUM.
- Enqueue-to-update latency: an entry accepted at edge N into an empty FIFO appears as prdt_en=1 after edge N+1.
- Sustained throughput is 1 update per cycle.
- An asynchronous reset mid-sweep or mid-drain discards everything and restarts CLEAR from index 0.

## Structure
- A shared package holds:
  - state encodings: CLEAR=2'd0, RUN=2'd1, DRAIN=2'd2;
  - the FIFO entry struct {index, taken}.
- The FIFO is one natural sub-module, lieat_bpu_upd_fifo: synchronous, with full/empty/count, push/pop, and registered storage.
- The FSM, arbiter and output register live in the top.

## Test plan
- Reset release with IDX_W=4:
  - clr_en high for exactly 16 cycles, clr_index 0..15;
  - readys low throughout, then high on cycle 16.
- req0 only, idx=5 taken=1: prdt_en pulses one cycle later with index 5, result 1.
- Both valid every cycle (req0 idx 1, req1 idx 2): grants alternate 0,1,0,1; prdt_index stream 1,2,1,2 at 1 per cycle.
- Stall the output side with a clear_req while 4 entries are queued:
  - readys are 0 next cycle;
  - the 4 prdt_en pulses drain in order;
  - clr_en starts only after the last one, and the two strobes never overlap.
- Fill the FIFO by pushing 4 entries while in DRAIN-free RUN with a forced no-pop test hook:
  - count reaches 4 and both readys are 0;
  - after a pop, ready returns; pointers wrap, verified by order of 6 entries.
- Assert reset mid-CLEAR at clr_index=7: the sweep restarts at 0 after deassertion, and prdt_en remains 0.
